// File: rtl/gb_interrupt_controller_pkg.sv
// Shared CPU-side definitions for the interrupt responder: source bit indices,
// bus addresses of IF/IE, and the state encodings of the IME and dispatch FSMs.
package gb_interrupt_controller_pkg;

  // Interrupt source bit positions (bit 0 is the highest priority).
  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  // Bus addresses decoded outside this block into i_Sel_IF / i_Sel_IE.
  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  // Master-enable sequencing: EI takes effect only after the next instruction.
  typedef enum logic [1:0] {
    IME_OFF  = 2'd0,
    IME_ARM1 = 2'd1,
    IME_ARM2 = 2'd2,
    IME_ON   = 2'd3
  } ime_state_e;

  // Dispatch sequencing between acknowledge and the fetch at the vector.
  typedef enum logic {
    DISP_IDLE   = 1'b0,
    DISP_ACTIVE = 1'b1
  } disp_state_e;

endpackage

// File: rtl/gb_interrupt_controller_irq_priority_encoder.sv
// Lowest-set-bit priority encoder: bit 0 wins. Shared with the HALT-bug logic.
module gb_interrupt_controller_irq_priority_encoder #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     pend,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    valid = |pend;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/gb_interrupt_controller.sv
// Interrupt responder: IF/IE registers, IME master-enable with delayed EI,
// prioritised dispatch request and restart vector for the CPU control unit.
module gb_interrupt_controller
  import gb_interrupt_controller_pkg::*;
#(
  parameter int          NUM_IRQ       = 5,
  parameter logic [7:0]  VECTOR_BASE   = 8'h40,
  parameter int          VECTOR_STRIDE = 8
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic [NUM_IRQ-1:0] i_Irq,
  input  logic               i_Sel_IF,
  input  logic               i_Sel_IE,
  input  logic               i_Write,
  input  logic [7:0]         i_Data,
  output logic [7:0]         o_Data,
  input  logic               i_EI,
  input  logic               i_EI_Now,
  input  logic               i_DI,
  input  logic               i_Fetch,
  input  logic               i_Int_Ack,
  output logic               o_Int_Req,
  output logic [7:0]         o_Vector,
  output logic               o_Wake,
  output logic               o_IME
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  // Elaboration-time sanity checks on the parameter set.
  if (NUM_IRQ < 1 || NUM_IRQ > 8) begin : g_bad_num_irq
    $error("NUM_IRQ must be in 1..8");
  end
  if (int'(VECTOR_BASE) + (NUM_IRQ - 1) * VECTOR_STRIDE > 255) begin : g_bad_vector
    $error("highest restart vector does not fit in 8 bits");
  end

  logic [NUM_IRQ-1:0] if_q;
  logic [NUM_IRQ-1:0] if_d;
  logic [NUM_IRQ-1:0] pend;
  logic [7:0]         ie_q;
  logic [7:0]         vector_q;
  logic [7:0]         vec_calc;
  logic [7:0]         rd_if;
  ime_state_e         ime_q;
  disp_state_e        disp_q;
  logic               enc_valid;
  logic [IDX_W-1:0]   enc_index;
  logic               ack_take;

  assign pend     = ie_q[NUM_IRQ-1:0] & if_q;
  assign ack_take = i_Int_Ack && (disp_q == DISP_IDLE);
  assign vec_calc = 8'(32'(VECTOR_BASE) + 32'(enc_index) * 32'(VECTOR_STRIDE));

  gb_interrupt_controller_irq_priority_encoder #(
    .N     (NUM_IRQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .pend  (pend),
    .valid (enc_valid),
    .index (enc_index)
  );

  // IF next value: hold < bus write < acknowledge clear < source set.
  always_comb begin
    if_d = if_q;
    if (i_Write && i_Sel_IF) if_d = i_Data[NUM_IRQ-1:0];
    if (ack_take && enc_valid) if_d[enc_index] = 1'b0;
    if_d = if_d | i_Irq;
  end

  // IF and IE storage.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      if_q <= '0;
      ie_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if_q <= if_d;
      if (i_Write && i_Sel_IE) ie_q <= i_Data;
    end
  end

  // IME master-enable FSM: acknowledge and DI dominate, RETI enables at once, EI arms.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ime_q <= IME_OFF;
    end else if (i_Int_Ack || i_DI) begin
      ime_q <= IME_OFF;
    end else if (i_EI_Now) begin
      ime_q <= IME_ON;
    end else begin
      case (ime_q)
        IME_OFF:  if (i_EI)    ime_q <= IME_ARM1;
        IME_ARM1: if (i_Fetch) ime_q <= IME_ARM2;
        IME_ARM2: if (i_Fetch) ime_q <= IME_ON;
        default:  ;
      endcase
    end
  end

  // Dispatch FSM and restart vector, latched at acknowledge and held until the fetch.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      disp_q   <= DISP_IDLE;
      vector_q <= 8'h00;
    end else if (ack_take) begin
      disp_q   <= DISP_ACTIVE;
      vector_q <= enc_valid ? vec_calc : 8'h00;
    end else if (disp_q == DISP_ACTIVE && i_Fetch) begin
      disp_q   <= DISP_IDLE;
    end
  end

  // Bus read mux; unimplemented IF bits read as 1.
  always_comb begin
    rd_if              = 8'hFF;
    rd_if[NUM_IRQ-1:0] = if_q;
    if (i_Sel_IF)      o_Data = rd_if;
    else if (i_Sel_IE) o_Data = ie_q;
    else               o_Data = 8'h00;
  end

  assign o_Int_Req = (ime_q == IME_ON) && (disp_q == DISP_IDLE) && enc_valid;
  assign o_Wake    = enc_valid;
  assign o_IME     = (ime_q == IME_ON);
  assign o_Vector  = vector_q;

endmodule

// File: tb/tb_gb_interrupt_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a behavioural model of the interrupt rules.
module tb_gb_interrupt_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] irq = '0;
  logic       sel_if = 1'b0, sel_ie = 1'b0, wr = 1'b0;
  logic [7:0] wdata = '0;
  logic       ei = 1'b0, ei_now = 1'b0, di = 1'b0, fetch = 1'b0, ack = 1'b0;
  logic [7:0] rdata, vector;
  logic       int_req, wake, ime;

  int n_checks = 0;
  int n_fail   = 0;

  gb_interrupt_controller dut (
    .i_Clk     (clk),
    .i_Rst_n   (rst_n),
    .i_Irq     (irq),
    .i_Sel_IF  (sel_if),
    .i_Sel_IE  (sel_ie),
    .i_Write   (wr),
    .i_Data    (wdata),
    .o_Data    (rdata),
    .i_EI      (ei),
    .i_EI_Now  (ei_now),
    .i_DI      (di),
    .i_Fetch   (fetch),
    .i_Int_Ack (ack),
    .o_Int_Req (int_req),
    .o_Vector  (vector),
    .o_Wake    (wake),
    .o_IME     (ime)
  );

  always #5 clk = ~clk;

  // Behavioural model: enable is "on" plus a count of fetches still to wait.
  typedef struct packed {
    logic [4:0] flags;
    logic [7:0] ie;
    bit         on;
    logic [1:0] wait_fetches;
    bit         in_dispatch;
    logic [7:0] vec;
  } model_t;

  model_t m = '0;

  function automatic int lowest_pending(model_t s);
    int lo = -1;
    for (int b = 4; b >= 0; b--) if (s.ie[b] && s.flags[b]) lo = b;
    return lo;
  endfunction

  function automatic model_t model_next(model_t s);
    model_t n;
    int lo;
    n  = s;
    lo = lowest_pending(s);
    if (wr && sel_if) n.flags = wdata[4:0];
    if (wr && sel_ie) n.ie = wdata;
    if (ack && !s.in_dispatch) begin
      n.in_dispatch = 1'b1;
      if (lo >= 0) begin
        n.flags[lo] = 1'b0;
        n.vec = 8'(64 + lo * 8);
      end else begin
        n.vec = 8'h00;
      end
    end else if (fetch && s.in_dispatch) begin
      n.in_dispatch = 1'b0;
    end
    n.flags = n.flags | irq;
    if (ack || di) begin
      n.on = 1'b0;
      n.wait_fetches = 2'd0;
    end else if (ei_now) begin
      n.on = 1'b1;
      n.wait_fetches = 2'd0;
    end else if (!s.on && s.wait_fetches == 2'd0) begin
      if (ei) n.wait_fetches = 2'd2;
    end else if (s.wait_fetches != 2'd0 && fetch) begin
      n.wait_fetches = s.wait_fetches - 2'd1;
      if (s.wait_fetches == 2'd1) n.on = 1'b1;
    end
    return n;
  endfunction

  function automatic bit model_req(model_t s);
    return s.on && !s.in_dispatch && (lowest_pending(s) >= 0);
  endfunction

  function automatic logic [7:0] model_rdata(model_t s);
    if (sel_if) return {3'b111, s.flags};
    if (sel_ie) return s.ie;
    return 8'h00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_next(m);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    check("cmp_int_req", {7'd0, int_req}, {7'd0, model_req(m)});
    check("cmp_wake",    {7'd0, wake},    {7'd0, lowest_pending(m) >= 0});
    check("cmp_ime",     {7'd0, ime},     {7'd0, m.on});
    check("cmp_vector",  vector,          m.vec);
    check("cmp_rdata",   rdata,           model_rdata(m));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    irq = '0; sel_if = 0; sel_ie = 0; wr = 0; wdata = '0;
    ei = 0; ei_now = 0; di = 0; fetch = 0; ack = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic write_ie(input logic [7:0] v);
    sel_ie = 1; wr = 1; wdata = v;
    tick();
  endtask

  task automatic read_if(output logic [7:0] v);
    sel_if = 1;
    #1;
    v = rdata;
    sel_if = 0;
  endtask

  logic [7:0] rd;

  initial begin
    tick();
    tick();
    check("reset_int_req", {7'd0, int_req}, 8'h00);
    check("reset_wake",    {7'd0, wake},    8'h00);
    check("reset_ime",     {7'd0, ime},     8'h00);
    check("reset_vector",  vector,          8'h00);
    check("reset_rdata",   rdata,           8'h00);
    rst_n = 1'b1;
    tick();

    // Scenario: two sources pending, RETI-style enable, ack services source 0.
    write_ie(8'h05);
    irq = 5'b00100; tick();
    irq = 5'b00001; tick();
    ei_now = 1; tick();
    check("t1_req", {7'd0, int_req}, 8'h01);
    ack = 1; tick();
    check("t1_vector", vector, 8'h40);
    check("t1_model_vector", m.vec, 8'h40);
    check("t1_ime", {7'd0, ime}, 8'h00);
    read_if(rd);
    check("t1_if", rd, 8'hE4);
    check("t1_model_if", {3'b000, m.flags}, 8'h04);
    fetch = 1; tick();

    // Scenario: EI delayed by two fetches.
    do_reset();
    write_ie(8'h01);
    irq = 5'b00001; tick();
    ei = 1; tick();
    check("t2_req_after_ei", {7'd0, int_req}, 8'h00);
    fetch = 1; tick();
    check("t2_req_after_fetch1", {7'd0, int_req}, 8'h00);
    fetch = 1; tick();
    check("t2_req_after_fetch2", {7'd0, int_req}, 8'h01);
    check("t2_ime", {7'd0, ime}, 8'h01);
    rst_n = 1'b0;
    #1;
    check("t2_async_reset_req", {7'd0, int_req}, 8'h00);
    tick();
    rst_n = 1'b1;

    // Scenario: DI beats EI; DI cancels a pending EI.
    do_reset();
    ei = 1; di = 1; tick();
    fetch = 1; tick();
    fetch = 1; tick();
    check("t3_ei_di_same", {7'd0, ime}, 8'h00);
    ei = 1; tick();
    di = 1; tick();
    fetch = 1; tick();
    fetch = 1; tick();
    check("t3_ei_then_di", {7'd0, ime}, 8'h00);

    // Scenario: request withdrawn by IE write before ack gives vector 0.
    do_reset();
    write_ie(8'h05);
    irq = 5'b00101; tick();
    ei_now = 1; tick();
    ack = 1; tick();
    check("t4_first_vector", vector, 8'h40);
    fetch = 1; tick();
    write_ie(8'h04);
    ei_now = 1; tick();
    check("t4_req", {7'd0, int_req}, 8'h01);
    write_ie(8'h00);
    ack = 1; tick();
    check("t4_vector_zero", vector, 8'h00);
    check("t4_ime", {7'd0, ime}, 8'h00);
    read_if(rd);
    check("t4_if_unchanged", rd, 8'hE4);
    fetch = 1; tick();

    // Scenario: source set beats a bus write of 0.
    do_reset();
    sel_if = 1; wr = 1; wdata = 8'h00; irq = 5'b00010; tick();
    read_if(rd);
    check("t5_if_read", rd, 8'hE2);

    // Scenario: wake without IME, dispatch of joypad, ignored re-ack, reset mid-dispatch.
    do_reset();
    write_ie(8'h10);
    irq = 5'b10000; tick();
    check("t6_wake", {7'd0, wake}, 8'h01);
    check("t6_req", {7'd0, int_req}, 8'h00);
    ei_now = 1; tick();
    ack = 1; tick();
    check("t6_vector", vector, 8'h60);
    irq = 5'b10000; tick();
    ack = 1; tick();
    check("t6_reack_ignored", vector, 8'h60);
    read_if(rd);
    check("t6_if_after_reack", rd, 8'hF0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_req",    {7'd0, int_req}, 8'h00);
    check("t6_rst_wake",   {7'd0, wake},    8'h00);
    check("t6_rst_ime",    {7'd0, ime},     8'h00);
    check("t6_rst_vector", vector,          8'h00);
    check("t6_rst_rdata",  rdata,           8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic; the CPU acknowledges only while not already dispatching.
    for (int i = 0; i < 3000; i++) begin
      irq    = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
      sel_if = ($urandom_range(0, 3) == 0);
      sel_ie = ($urandom_range(0, 3) == 0);
      wr     = ($urandom_range(0, 2) == 0);
      wdata  = 8'($urandom);
      ei     = ($urandom_range(0, 9) == 0);
      ei_now = ($urandom_range(0, 19) == 0);
      di     = ($urandom_range(0, 14) == 0);
      fetch  = ($urandom_range(0, 2) == 0);
      if (!m.in_dispatch)
        ack = model_req(m) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gb_interrupt_controller.md
Name: gb_interrupt_controller

Overview:
- Interrupt responder paired with the control unit's EI/RETI/CALL-style dispatch sequencing.
- Holds the IF (0xFF0F) and IE (0xFFFF) registers and the IME master-enable, including the delayed-enable rule for EI.
- Presents a prioritised request and restart vector to the CPU, and clears the serviced flag on the CPU's acknowledge.
- Sits between the peripheral IRQ sources and the CPU control unit; IF/IE are reached over the CPU data bus.

Parameters:
NUM_IRQ, 5, number of interrupt sources (bit 0 highest priority)
VECTOR_BASE, 8'h40, restart address of source 0
VECTOR_STRIDE, 8, address step between consecutive source vectors

Ports:
i_Clk  in  1  system clock, all state rising-edge
i_Rst_n  in  1  asynchronous active-low reset
i_Irq  in  NUM_IRQ  one-cycle set pulses from peripherals (VBlank, STAT, Timer, Serial, Joypad)
i_Sel_IF  in  1  bus address decodes to IF
i_Sel_IE  in  1  bus address decodes to IE
i_Write  in  1  bus write strobe
i_Data  in  8  bus write data
o_Data  out  8  bus read data; IF reads {3'b111, IF}, IE reads IE, else 8'h00
i_EI  in  1  EI instruction executing (pulse)
i_EI_Now  in  1  RETI enable, immediate (pulse)
i_DI  in  1  DI instruction executing (pulse)
i_Fetch  in  1  CPU opcode-fetch boundary (pulse)
i_Int_Ack  in  1  CPU begins dispatch (pulse)
o_Int_Req  out  1  interrupt dispatch requested
o_Vector  out  8  restart address latched at acknowledge
o_Wake  out  1  pending interrupt, ignoring IME (HALT/STOP exit)
o_IME  out  1  current master-enable

Behaviour:
- Reset (async, i_Rst_n=0):
  - Registers: IF=0, IE=0, IME state=OFF, dispatch state=IDLE, o_Vector=8'h00.
  - Outputs: o_Int_Req=0, o_Wake=0, o_IME=0, o_Data=8'h00.
- Pending vector: pend = IE[NUM_IRQ-1:0] & IF. Priority is the lowest set bit.
- IF update precedence per bit, lowest to highest: hold < bus write < ack clear < i_Irq set.
  - A source pulse in the same cycle as a write-0 or an ack clear leaves the bit at 1.
- IE is a full 8-bit read/write register. Writes take effect on the next edge.
- IME state machine:
  - OFF -> ARM1 on i_EI.
  - ARM1 -> ARM2 on i_Fetch (the fetch that ends EI).
  - ARM2 -> ON on i_Fetch (the fetch that ends the following instruction).
  - Any state -> ON on i_EI_Now.
  - Any state -> OFF on i_DI or i_Int_Ack.
  - Simultaneous events: i_DI beats i_EI/i_EI_Now; i_Int_Ack beats everything.
  - i_EI while in ARM1, ARM2 or ON: state is unchanged (no restart).
- o_IME=1 only in state ON.
- Dispatch state machine:
  - IDLE -> DISPATCH on i_Int_Ack.
  - DISPATCH -> IDLE on i_Fetch.
- o_Int_Req = (IME==ON) & (dispatch==IDLE) & |pend. Combinational from registers; no input-to-output path.
- On i_Int_Ack:
  - Compute the lowest set bit n of pend in that same cycle.
  - Next edge: IF[n] cleared, o_Vector = VECTOR_BASE + n*VECTOR_STRIDE. Vector is stable throughout DISPATCH.
  - If pend==0 at ack (IE/IF changed after the request), o_Vector=8'h00 and no IF bit is cleared.
  - i_Int_Ack while already in DISPATCH is ignored.
- o_Wake = |pend, combinational from registers, independent of IME and dispatch state.
- Vector arithmetic is 8-bit; the width must hold VECTOR_BASE + (NUM_IRQ-1)*VECTOR_STRIDE without overflow (checked by elaboration-time assertion).
- Reset asserted mid-dispatch: returns to IDLE immediately and drops o_Int_Req asynchronously.

Decomposition:
- Shared CPU package: IRQ bit indices (VBLANK=0, STAT=1, TIMER=2, SERIAL=3, JOYPAD=4), IF/IE addresses, IME state encoding (OFF/ARM1/ARM2/ON), dispatch state encoding.
- One natural sub-module: irq_priority_encoder (NUM_IRQ-bit pend -> valid + index), combinational, reused by the HALT-bug logic.

Test Plan:
- IE=8'h05, pulse i_Irq=5'b00100 then 5'b00001, i_EI_Now -> o_Int_Req=1. Ack -> o_Vector=8'h40, IF=5'b00100, o_IME=0.
- i_EI, then i_Fetch, i_Fetch with IE=8'h01 and IF[0]=1 -> o_Int_Req=0 after the first fetch, 1 only after the second.
- i_EI and i_DI in the same cycle -> IME stays OFF. i_EI then i_DI before the first fetch -> IME OFF after both fetches.
- IME=ON, IE=8'h04, IF=5'b00100, o_Int_Req=1. Write IE=8'h00, then ack -> o_Vector=8'h00, IF unchanged, IME=OFF.
- Write IF=8'h00 in the same cycle as i_Irq[1] -> IF=5'b00010. Read IF -> o_Data=8'hE2.
- IME=OFF, IE=8'h10, pulse i_Irq[4] -> o_Wake=1, o_Int_Req=0. Assert reset mid-DISPATCH -> all outputs 0 immediately.
